// File: rtl/seg_clock_mux.sv
// Real-time clock (SS, MM, HH and optional DD) kept as a synchronous BCD
// carry chain, with a programmable 1 Hz prescaler, run/hold, manual
// minute/hour setting and a one-digit-per-cycle 7-segment scan.
module seg_clock_mux #(
  parameter int unsigned DIGITS         = 8,
  parameter int unsigned TICK_DIV       = 1000,
  parameter bit          COM_ACTIVE_LOW = 1'b1
) (
  input  logic              clk_1k,
  input  logic              reset,
  input  logic              run,
  input  logic              set_min,
  input  logic              set_hour,
  output logic [7:0]        seg_data,
  output logic [DIGITS-1:0] seg_com,
  output logic              sec_tick
);

  localparam logic [15:0] PC_LAST  = 16'(TICK_DIV - 1);
  localparam logic [2:0]  SEL_LAST = 3'(DIGITS - 1);
  localparam bit          HAS_DAYS = (DIGITS == 8);

  logic [15:0] pcnt, pcnt_n;
  logic [3:0]  s1, s10, m1, m10, h1, h10, d1, d10;
  logic [3:0]  s1_n, s10_n, m1_n, m10_n, h1_n, h10_n, d1_n, d10_n;
  logic [3:0]  m1_inc, m10_inc, h1_inc, h10_inc;
  logic        tick, set_any, s_wrap, m_wrap, h_wrap;

  logic [2:0]        sel;
  logic [3:0]        cur_digit;
  logic [6:0]        glyph;
  logic              dp;
  logic [DIGITS-1:0] com_onehot;

  // Minute and hour "+1" values, shared by the carry chain and the set buttons
  always_comb begin
    m1_inc  = m1 + 4'd1;
    m10_inc = m10;
    if (m1 == 4'd9) begin
      m1_inc  = '0;
      m10_inc = (m10 == 4'd5) ? '0 : m10 + 4'd1;
    end
    h1_inc  = h1 + 4'd1;
    h10_inc = h10;
    if (h10 == 4'd2 && h1 == 4'd3) begin
      h1_inc  = '0;
      h10_inc = '0;
    end else if (h1 == 4'd9) begin
      h1_inc  = '0;
      h10_inc = h10 + 4'd1;
    end
  end

  // Prescaler and time next-state; set buttons win over (and swallow) a tick
  always_comb begin
    tick    = run && (pcnt == PC_LAST);
    set_any = set_min | set_hour;
    s_wrap  = (s1 == 4'd9) && (s10 == 4'd5);
    m_wrap  = (m1 == 4'd9) && (m10 == 4'd5);
    h_wrap  = (h10 == 4'd2) && (h1 == 4'd3);

    pcnt_n = pcnt;
    s1_n   = s1;   s10_n = s10;
    m1_n   = m1;   m10_n = m10;
    h1_n   = h1;   h10_n = h10;
    d1_n   = d1;   d10_n = d10;

    // A swallowed tick still restarts the second so the next one is a full period away
    if (set_min || tick) pcnt_n = '0;
    else if (run)        pcnt_n = pcnt + 16'd1;

    if (set_any) begin
      if (set_min) begin
        s1_n  = '0;
        s10_n = '0;
        m1_n  = m1_inc;
        m10_n = m10_inc;
      end
      if (set_hour) begin
        h1_n  = h1_inc;
        h10_n = h10_inc;
      end
    end else if (tick) begin
      if (s1 == 4'd9) begin
        s1_n  = '0;
        s10_n = (s10 == 4'd5) ? '0 : s10 + 4'd1;
      end else begin
        s1_n = s1 + 4'd1;
      end
      if (s_wrap) begin
        m1_n  = m1_inc;
        m10_n = m10_inc;
      end
      if (s_wrap && m_wrap) begin
        h1_n  = h1_inc;
        h10_n = h10_inc;
      end
      if (HAS_DAYS && s_wrap && m_wrap && h_wrap) begin
        if (d1 == 4'd9) begin
          d1_n  = '0;
          d10_n = (d10 == 4'd9) ? '0 : d10 + 4'd1;
        end else begin
          d1_n = d1 + 4'd1;
        end
      end
    end
  end

  // Time-keeping registers and the registered seconds strobe
  always_ff @(posedge clk_1k or negedge reset) begin
    if (!reset) begin
      pcnt     <= '0;
      s1       <= '0;  s10 <= '0;
      m1       <= '0;  m10 <= '0;
      h1       <= '0;  h10 <= '0;
      d1       <= '0;  d10 <= '0;
      sec_tick <= 1'b0;
    end else begin
      pcnt     <= pcnt_n;
      s1       <= s1_n;  s10 <= s10_n;
      m1       <= m1_n;  m10 <= m10_n;
      h1       <= h1_n;  h10 <= h10_n;
      d1       <= d1_n;  d10 <= d10_n;
      sec_tick <= tick & ~set_any;
    end
  end

  // Digit mux, glyph decode, colon dp and common select for the current scan slot
  always_comb begin
    case (sel)
      3'd0:    cur_digit = s1;
      3'd1:    cur_digit = s10;
      3'd2:    cur_digit = m1;
      3'd3:    cur_digit = m10;
      3'd4:    cur_digit = h1;
      3'd5:    cur_digit = h10;
      3'd6:    cur_digit = d1;
      3'd7:    cur_digit = d10;
      default: cur_digit = '0;
    endcase
    case (cur_digit)
      4'd0:    glyph = 7'h3F;
      4'd1:    glyph = 7'h06;
      4'd2:    glyph = 7'h5B;
      4'd3:    glyph = 7'h4F;
      4'd4:    glyph = 7'h66;
      4'd5:    glyph = 7'h6D;
      4'd6:    glyph = 7'h7D;
      4'd7:    glyph = 7'h07;
      4'd8:    glyph = 7'h7F;
      4'd9:    glyph = 7'h6F;
      default: glyph = '0;
    endcase
    dp         = ((sel == 3'd2) || (sel == 3'd4)) && !s1[0];
    com_onehot = {{(DIGITS-1){1'b0}}, 1'b1} << sel;
  end

  // Scan registers: select and pattern come from the same sel, so they never disagree
  always_ff @(posedge clk_1k or negedge reset) begin
    if (!reset) begin
      sel      <= '0;
      seg_data <= '0;
      seg_com  <= {DIGITS{COM_ACTIVE_LOW}};
    end else begin
      sel      <= (sel == SEL_LAST) ? '0 : sel + 3'd1;
      seg_data <= {dp, glyph};
      seg_com  <= COM_ACTIVE_LOW ? ~com_onehot : com_onehot;
    end
  end

endmodule
